// File: rtl/cpu_defs.sv
// Shared definitions for the RAM1 port arbiter: FSM states, grant selects, latched access record.
package cpu_defs;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } ram1_state_t;

    localparam logic GNT_IF  = 1'b0;
    localparam logic GNT_MEM = 1'b1;

    // Everything about the access in flight, captured when it leaves IDLE.
    typedef struct packed {
        logic              gnt;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } ram1_acc_t;

endpackage

// File: rtl/ram1_strobe_timer.sv
// Loadable down-counter timing the SRAM strobe; done is combinational on a zero count.
// Load takes effect next cycle; counts only while en is high, no backpressure.
module ram1_strobe_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/ram1_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one async SRAM; ack 2+STROBE_CYCLES cycles after grant.
// Requesters hold req until their one-cycle ack; stall reports any pending unacked request.
module ram1_arbiter
    import cpu_defs::*;
#(
    parameter int STROBE_CYCLES = 1,
    parameter int IF_STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [17:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_ack,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [17:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_ack,
    output logic        stall,
    output logic [17:0] Ram1Addr,
    inout  wire  [15:0] Ram1Data,
    output logic        Ram1OE,
    output logic        Ram1WE,
    output logic        Ram1EN
);

    localparam int          SW          = (IF_STARVE_MAX < 1) ? 1 : $clog2(IF_STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(IF_STARVE_MAX);
    localparam logic [2:0]  STROBE_LOAD = 3'(STROBE_CYCLES - 1);

    ram1_state_t   state_q, state_d;
    ram1_acc_t     acc_q;
    logic [SW-1:0] starve_q;
    logic [15:0]   if_rdata_q, mem_rdata_q;
    logic          start, gnt_sel, tmr_done, starve_full;

    ram1_strobe_timer #(.W(3)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state_q == SETUP),
        .load_val (STROBE_LOAD),
        .en       (state_q == STROBE),
        .done     (tmr_done)
    );

    assign starve_full = (starve_q == STARVE_TOP);

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        // MEM wins unless IF has been passed over IF_STARVE_MAX times in a row.
        gnt_sel = (mem_req && !(if_req && starve_full)) ? GNT_MEM : GNT_IF;
        case (state_q)
            IDLE: begin
                if (if_req || mem_req) begin
                    start   = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP:   state_d = STROBE;
            STROBE:  if (tmr_done) state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            starve_q    <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                acc_q <= '{gnt:   gnt_sel,
                           we:    (gnt_sel == GNT_MEM) && mem_we,
                           addr:  (gnt_sel == GNT_MEM) ? mem_addr : if_addr,
                           wdata: mem_wdata};
                if (gnt_sel == GNT_IF) begin
                    starve_q <= '0;
                end else if (if_req && !starve_full) begin
                    starve_q <= starve_q + 1'b1;
                end
            end
            // Capture on the last strobe cycle, while OE is still low.
            if ((state_q == STROBE) && tmr_done && !acc_q.we) begin
                if (acc_q.gnt == GNT_IF) begin
                    if_rdata_q <= Ram1Data;
                end else begin
                    mem_rdata_q <= Ram1Data;
                end
            end
        end
    end

    assign Ram1Addr  = acc_q.addr;
    assign Ram1EN    = (state_q == IDLE);
    assign Ram1OE    = !((state_q == STROBE) && !acc_q.we);
    assign Ram1WE    = !((state_q == STROBE) && acc_q.we);
    assign Ram1Data  = ((state_q != IDLE) && acc_q.we) ? acc_q.wdata : 16'hzzzz;

    assign if_ack    = (state_q == HOLD) && (acc_q.gnt == GNT_IF);
    assign mem_ack   = (state_q == HOLD) && (acc_q.gnt == GNT_MEM);
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign stall     = (if_req && !if_ack) || (mem_req && !mem_ack);

endmodule
